// File: rtl/fifo_sync_v2_pkg.sv
// Shared types and helpers for the fifo_sync_v2 FIFO.
// Holds the read-mode enum, the index-wrap function and the parity function.
package fifo_sync_v2_pkg;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    localparam int PARITY_MAX_W = 1024;

    // Explicit wrap keeps non-power-of-2 depths correct.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fifo_sync_v2_mem.sv
// Simple dual-port storage for fifo_sync_v2.
// One synchronous write port and one asynchronous read port; contents are never reset.
module fifo_sync_v2_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_v2.sv
// Single-clock FIFO with any depth, standard or FWFT read mode, programmable almost flags,
// sticky error flags and flush. Define FIFO_SYNC_V2_PARITY_EN to add per-entry parity and parity_err.
module fifo_sync_v2
    import fifo_sync_v2_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 16,
    parameter int  FWFT       = 0,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  flush,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    input  logic                  clr_err,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
`ifdef FIFO_SYNC_V2_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  underflow
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef FIFO_SYNC_V2_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif
    localparam fifo_mode_e MODE = (FWFT != 0) ? MODE_FWFT : MODE_STD;

    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [MEM_W-1:0] wdata, rdata;
    logic             rd_ok, wr_ok, do_rd, do_wr;

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    // A write while full is admitted only when a read frees a slot in the same cycle.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);
    assign do_rd = rd_ok && !flush;
    assign do_wr = wr_ok && !flush;

`ifdef FIFO_SYNC_V2_PARITY_EN
    logic rd_par_err;
    assign wdata      = {even_parity(PARITY_MAX_W'(din)), din};
    assign rd_par_err = even_parity(PARITY_MAX_W'(rdata[DATA_WIDTH-1:0])) != rdata[DATA_WIDTH];
`else
    assign wdata = din;
`endif

    fifo_sync_v2_mem #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_idx),
        .wdata (wdata),
        .raddr (rd_idx),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_idx <= IDX_W'(next_idx(32'(wr_idx), DEPTH));
            if (do_rd) rd_idx <= IDX_W'(next_idx(32'(rd_idx), DEPTH));
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error event takes priority over clr_err; flush neither sets nor clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_ok && !flush) overflow <= 1'b1;
            else if (clr_err)              overflow <= 1'b0;
            if (rd_en && !rd_ok && !flush) underflow <= 1'b1;
            else if (clr_err)              underflow <= 1'b0;
        end
    end

    generate
        if (MODE == MODE_STD) begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
`ifdef FIFO_SYNC_V2_PARITY_EN
                    parity_err <= 1'b0;
`endif
                end else if (flush) begin
                    dout_valid <= 1'b0;
`ifdef FIFO_SYNC_V2_PARITY_EN
                    parity_err <= 1'b0;
`endif
                end else begin
                    dout_valid <= do_rd;
                    if (do_rd) dout <= rdata[DATA_WIDTH-1:0];
`ifdef FIFO_SYNC_V2_PARITY_EN
                    parity_err <= do_rd && rd_par_err;
`endif
                end
            end
        end else begin : g_fwft
            assign dout       = rdata[DATA_WIDTH-1:0];
            assign dout_valid = !empty;
`ifdef FIFO_SYNC_V2_PARITY_EN
            assign parity_err = !empty && rd_par_err;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_v2.sv
// Directed self-checking bench for fifo_sync_v2 (DEPTH=5), one standard-mode and one FWFT instance.
module tb_fifo_sync_v2;

    localparam int DW = 8;
    localparam int DP = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] af_thresh, ae_thresh;

    logic          s_wr_en, s_rd_en, s_flush, s_clr_err;
    logic [DW-1:0] s_din, s_dout;
    logic          s_dout_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [CW-1:0] s_count;

    logic          f_wr_en, f_rd_en, f_flush, f_clr_err;
    logic [DW-1:0] f_din, f_dout;
    logic          f_dout_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] f_count;

`ifdef FIFO_SYNC_V2_PARITY_EN
    logic s_perr, f_perr;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_sync_v2 #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .din(s_din), .rd_en(s_rd_en),
        .dout(s_dout), .dout_valid(s_dout_valid), .flush(s_flush),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(s_clr_err),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_count), .overflow(s_ovf),
`ifdef FIFO_SYNC_V2_PARITY_EN
        .parity_err(s_perr),
`endif
        .underflow(s_unf)
    );

    fifo_sync_v2 #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
        .dout(f_dout), .dout_valid(f_dout_valid), .flush(f_flush),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(f_clr_err),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf),
`ifdef FIFO_SYNC_V2_PARITY_EN
        .parity_err(f_perr),
`endif
        .underflow(f_unf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_wr_en = 0; s_rd_en = 0; s_flush = 0; s_clr_err = 0; s_din = '0;
        f_wr_en = 0; f_rd_en = 0; f_flush = 0; f_clr_err = 0; f_din = '0;
    endtask

    task automatic test_reset();
        checks++; if (s_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", s_count); end
        checks++; if (s_empty !== 1'b1 || s_full !== 1'b0) begin errors++; $display("FAIL rst_flags: empty=%b full=%b want 1 0", s_empty, s_full); end
        checks++; if (s_dout !== 8'h00 || s_dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout: dout=%h valid=%b want 00 0", s_dout, s_dout_valid); end
        checks++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin errors++; $display("FAIL rst_err: ovf=%b unf=%b want 0 0", s_ovf, s_unf); end
        checks++; if (f_dout_valid !== 1'b0 || f_empty !== 1'b1) begin errors++; $display("FAIL rst_fwft: valid=%b empty=%b want 0 1", f_dout_valid, f_empty); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) begin
            s_wr_en = 1; s_din = 8'hA1 + 8'(i);
            step();
        end
        idle();
        checks++; if (s_full !== 1'b1 || s_count !== 3'd5) begin errors++; $display("FAIL fill: full=%b count=%0d want 1 5", s_full, s_count); end
        checks++; if (s_dout_valid !== 1'b0) begin errors++; $display("FAIL fill_novalid: got %b want 0", s_dout_valid); end
        for (int i = 0; i < 5; i++) begin
            s_rd_en = 1;
            step();
            checks++;
            if (s_dout !== 8'hA1 + 8'(i) || s_dout_valid !== 1'b1) begin
                errors++; $display("FAIL drain_%0d: dout=%h valid=%b want %h 1", i, s_dout, s_dout_valid, 8'hA1 + 8'(i));
            end
`ifdef FIFO_SYNC_V2_PARITY_EN
            checks++; if (s_perr !== 1'b0) begin errors++; $display("FAIL parity_%0d: got %b want 0", i, s_perr); end
`endif
        end
        idle();
        step();
        checks++; if (s_dout_valid !== 1'b0 || s_empty !== 1'b1 || s_dout !== 8'hA5) begin
            errors++; $display("FAIL drain_end: valid=%b empty=%b dout=%h want 0 1 a5", s_dout_valid, s_empty, s_dout);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin s_wr_en = 1; s_din = 8'hB0 + 8'(i); step(); end
        idle();
        for (int i = 0; i < 3; i++) begin
            s_rd_en = 1; step();
            checks++; if (s_dout !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL wrap_pre_%0d: dout=%h want %h", i, s_dout, 8'hB0 + 8'(i)); end
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            s_wr_en = 1; s_din = 8'hC0 + 8'(i); step();
            checks++; if (s_count !== 3'(i + 1)) begin errors++; $display("FAIL wrap_wcount_%0d: count=%0d want %0d", i, s_count, i + 1); end
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            s_rd_en = 1; step();
            checks++; if (s_dout !== 8'hC0 + 8'(i) || s_count !== 3'(4 - i)) begin
                errors++; $display("FAIL wrap_rd_%0d: dout=%h count=%0d want %h %0d", i, s_dout, s_count, 8'hC0 + 8'(i), 4 - i);
            end
        end
        idle();
    endtask

    task automatic test_full_bypass();
        for (int i = 0; i < 5; i++) begin s_wr_en = 1; s_din = 8'hD0 + 8'(i); step(); end
        s_wr_en = 1; s_rd_en = 1; s_din = 8'hE0;
        step();
        checks++; if (s_count !== 3'd5 || s_dout !== 8'hD0 || s_dout_valid !== 1'b1 || s_ovf !== 1'b0) begin
            errors++; $display("FAIL bypass: count=%0d dout=%h valid=%b ovf=%b want 5 d0 1 0", s_count, s_dout, s_dout_valid, s_ovf);
        end
        s_rd_en = 0; s_din = 8'hE1;
        step();
        checks++; if (s_count !== 3'd5 || s_ovf !== 1'b1) begin errors++; $display("FAIL overflow: count=%0d ovf=%b want 5 1", s_count, s_ovf); end
        idle(); s_clr_err = 1;
        step();
        checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: ovf=%b want 0", s_ovf); end
        idle();
        for (int i = 0; i < 5; i++) begin
            logic [7:0] exp;
            exp = (i < 4) ? 8'hD1 + 8'(i) : 8'hE0;
            s_rd_en = 1; step();
            checks++; if (s_dout !== exp) begin errors++; $display("FAIL bypass_rd_%0d: dout=%h want %h", i, s_dout, exp); end
        end
        idle();
    endtask

    task automatic test_underflow();
        s_rd_en = 1;
        step();
        checks++; if (s_unf !== 1'b1 || s_dout !== 8'hE0 || s_dout_valid !== 1'b0) begin
            errors++; $display("FAIL underflow: unf=%b dout=%h valid=%b want 1 e0 0", s_unf, s_dout, s_dout_valid);
        end
        idle(); s_clr_err = 1;
        step();
        checks++; if (s_unf !== 1'b0) begin errors++; $display("FAIL clr_unf: unf=%b want 0", s_unf); end
        idle(); s_wr_en = 1; s_rd_en = 1; s_din = 8'hF0;
        step();
        checks++; if (s_count !== 3'd1 || s_unf !== 1'b1 || s_dout_valid !== 1'b0) begin
            errors++; $display("FAIL empty_wr_rd: count=%0d unf=%b valid=%b want 1 1 0", s_count, s_unf, s_dout_valid);
        end
        idle(); s_clr_err = 1; s_rd_en = 1;
        step();
        checks++; if (s_dout !== 8'hF0 || s_unf !== 1'b0 || s_empty !== 1'b1) begin
            errors++; $display("FAIL empty_wr_rd_data: dout=%h unf=%b empty=%b want f0 0 1", s_dout, s_unf, s_empty);
        end
        idle();
    endtask

    task automatic test_fwft();
        f_wr_en = 1; f_din = 8'h3C;
        step();
        idle();
        checks++; if (f_dout !== 8'h3C || f_dout_valid !== 1'b1) begin errors++; $display("FAIL fwft_first: dout=%h valid=%b want 3c 1", f_dout, f_dout_valid); end
        f_rd_en = 1;
        step();
        idle();
        checks++; if (f_empty !== 1'b1 || f_dout_valid !== 1'b0) begin errors++; $display("FAIL fwft_ack: empty=%b valid=%b want 1 0", f_empty, f_dout_valid); end
        f_wr_en = 1; f_din = 8'h11; step();
        f_din = 8'h22; step();
        idle(); f_rd_en = 1;
        step();
        idle();
        checks++; if (f_dout !== 8'h22 || f_count !== 3'd1) begin errors++; $display("FAIL fwft_next: dout=%h count=%0d want 22 1", f_dout, f_count); end
        f_rd_en = 1; step(); idle();
    endtask

    task automatic test_thresholds();
        af_thresh = 3'd3; ae_thresh = 3'd1;
        #1;
        checks++; if (s_ae !== 1'b1 || s_af !== 1'b0) begin errors++; $display("FAIL thr_0: ae=%b af=%b want 1 0", s_ae, s_af); end
        for (int i = 1; i <= 4; i++) begin
            s_wr_en = 1; s_din = 8'(i); step();
            checks++;
            if (s_ae !== (i <= 1) || s_af !== (i >= 3)) begin
                errors++; $display("FAIL thr_%0d: ae=%b af=%b want %b %b", i, s_ae, s_af, i <= 1, i >= 3);
            end
        end
        s_wr_en = 1; s_rd_en = 1; s_flush = 1;
        step();
        idle();
        checks++; if (s_count !== 3'd0 || s_empty !== 1'b1 || s_ovf !== 1'b0 || s_unf !== 1'b0 || s_dout_valid !== 1'b0) begin
            errors++; $display("FAIL flush: count=%0d empty=%b ovf=%b unf=%b valid=%b want 0 1 0 0 0", s_count, s_empty, s_ovf, s_unf, s_dout_valid);
        end
        for (int i = 0; i < 6; i++) begin s_wr_en = 1; s_din = 8'h50 + 8'(i); step(); end
        idle();
        checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL pre_flush_ovf: ovf=%b want 1", s_ovf); end
        s_flush = 1; s_wr_en = 1;
        step();
        idle();
        checks++; if (s_count !== 3'd0 || s_ovf !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovf: count=%0d ovf=%b want 0 1", s_count, s_ovf); end
        s_wr_en = 1; s_din = 8'h77; step();
        idle(); s_rd_en = 1; s_clr_err = 1; step(); idle();
        checks++; if (s_dout !== 8'h77 || s_ovf !== 1'b0) begin errors++; $display("FAIL post_flush_rd: dout=%h ovf=%b want 77 0", s_dout, s_ovf); end
    endtask

    task automatic test_reset_mid();
        s_wr_en = 1; s_din = 8'h91; step();
        s_din = 8'h92; step();
        idle(); s_rd_en = 1; step(); idle();
        #2 rst_n = 0;
        #1;
        checks++; if (s_count !== 3'd0 || s_dout_valid !== 1'b0 || s_dout !== 8'h00) begin
            errors++; $display("FAIL mid_reset: count=%0d valid=%b dout=%h want 0 0 00", s_count, s_dout_valid, s_dout);
        end
        #2 rst_n = 1;
        step();
        checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL mid_reset_empty: empty=%b want 1", s_empty); end
    endtask

    initial begin
        rst_n = 0;
        af_thresh = 3'd5; ae_thresh = 3'd0;
        idle();
        step(); step();
        test_reset();
        rst_n = 1;
        step();
        test_fill_drain();
        test_wrap();
        test_full_bypass();
        test_underflow();
        test_fwft();
        test_thresholds();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
